// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the command sequencer: frame command codes,
// sequencer states and the register addresses that hold ALU operands.
package sys_ctrl_pkg;

    localparam logic [7:0] WR_CMD      = 8'hAA;
    localparam logic [7:0] RD_CMD      = 8'hBB;
    localparam logic [7:0] ALU_OP_CMD  = 8'hCC;
    localparam logic [7:0] ALU_NOP_CMD = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        RD_SEND,
        OPA,
        OPB,
        FUN,
        ALU_WAIT,
        SEND_LO,
        SEND_HI
    } state_t;

endpackage

// File: rtl/sys_ctrl.sv
// Command sequencer: decodes RX frames into register-file and ALU operations
// and returns read data / ALU results through the TX FIFO.
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    FIFO_FULL,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    CLK_EN,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [DATA_WIDTH-1:0]   WrData,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD
);

    localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [2*DATA_WIDTH-1:0] result_reg, result_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   wr_data_reg, wr_data_next;
    logic [DATA_WIDTH-1:0]   tx_data_reg, tx_data_next;
    logic [FUN_WIDTH-1:0]    alu_fun_reg, alu_fun_next;
    logic                    alu_en_reg, alu_en_next;
    logic                    clk_en_reg, clk_en_next;
    logic                    wr_en_reg, wr_en_next;
    logic                    rd_en_reg, rd_en_next;
    logic                    tx_vld_reg, tx_vld_next;
    logic                    wait_expired;

    assign wait_expired = (cnt_reg == CNT_W'(WAIT_LIMIT - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            result_reg  <= '0;
            addr_reg    <= '0;
            wr_data_reg <= '0;
            tx_data_reg <= '0;
            alu_fun_reg <= '0;
            alu_en_reg  <= 1'b0;
            clk_en_reg  <= 1'b0;
            wr_en_reg   <= 1'b0;
            rd_en_reg   <= 1'b0;
            tx_vld_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            result_reg  <= result_next;
            addr_reg    <= addr_next;
            wr_data_reg <= wr_data_next;
            tx_data_reg <= tx_data_next;
            alu_fun_reg <= alu_fun_next;
            alu_en_reg  <= alu_en_next;
            clk_en_reg  <= clk_en_next;
            wr_en_reg   <= wr_en_next;
            rd_en_reg   <= rd_en_next;
            tx_vld_reg  <= tx_vld_next;
        end
    end

    // Strobes default low every cycle; data/address/function hold their values.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        result_next  = result_reg;
        addr_next    = addr_reg;
        wr_data_next = wr_data_reg;
        tx_data_next = tx_data_reg;
        alu_fun_next = alu_fun_reg;
        clk_en_next  = clk_en_reg;
        alu_en_next  = 1'b0;
        wr_en_next   = 1'b0;
        rd_en_next   = 1'b0;
        tx_vld_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == DATA_WIDTH'(WR_CMD))           state_next = WR_ADDR;
                    else if (RX_P_DATA == DATA_WIDTH'(RD_CMD))      state_next = RD_ADDR;
                    else if (RX_P_DATA == DATA_WIDTH'(ALU_OP_CMD))  state_next = OPA;
                    else if (RX_P_DATA == DATA_WIDTH'(ALU_NOP_CMD)) state_next = FUN;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_next  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_next   = 1'b1;
                    wr_data_next = RX_P_DATA;
                    state_next   = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rd_en_next = 1'b1;
                    addr_next  = RX_P_DATA[ADDR_WIDTH-1:0];
                    cnt_next   = '0;
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // A valid arriving on the last allowed cycle still wins over the abort.
                if (RdData_Valid) begin
                    result_next                 = '0;
                    result_next[DATA_WIDTH-1:0] = RdData;
                    state_next                  = RD_SEND;
                end else if (wait_expired) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RD_SEND: begin
                if (!FIFO_FULL) begin
                    tx_vld_next  = 1'b1;
                    tx_data_next = result_reg[DATA_WIDTH-1:0];
                    state_next   = IDLE;
                end
            end
            OPA: begin
                if (RX_D_VLD) begin
                    wr_en_next   = 1'b1;
                    addr_next    = ADDR_WIDTH'(OPA_ADDR);
                    wr_data_next = RX_P_DATA;
                    state_next   = OPB;
                end
            end
            OPB: begin
                if (RX_D_VLD) begin
                    wr_en_next   = 1'b1;
                    addr_next    = ADDR_WIDTH'(OPB_ADDR);
                    wr_data_next = RX_P_DATA;
                    state_next   = FUN;
                end
            end
            FUN: begin
                if (RX_D_VLD) begin
                    alu_fun_next = RX_P_DATA[FUN_WIDTH-1:0];
                    alu_en_next  = 1'b1;
                    clk_en_next  = 1'b1;
                    cnt_next     = '0;
                    state_next   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    result_next = ALU_OUT;
                    clk_en_next = 1'b0;
                    state_next  = SEND_LO;
                end else if (wait_expired) begin
                    clk_en_next = 1'b0;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            SEND_LO: begin
                if (!FIFO_FULL) begin
                    tx_vld_next  = 1'b1;
                    tx_data_next = result_reg[DATA_WIDTH-1:0];
                    state_next   = SEND_HI;
                end
            end
            SEND_HI: begin
                if (!FIFO_FULL) begin
                    tx_vld_next  = 1'b1;
                    tx_data_next = result_reg[2*DATA_WIDTH-1:DATA_WIDTH];
                    state_next   = IDLE;
                end
            end
            default: begin
                clk_en_next = 1'b0;
                state_next  = IDLE;
            end
        endcase
    end

    assign ALU_EN    = alu_en_reg;
    assign ALU_FUN   = alu_fun_reg;
    assign CLK_EN    = clk_en_reg;
    assign Address   = addr_reg;
    assign WrEn      = wr_en_reg;
    assign RdEn      = rd_en_reg;
    assign WrData    = wr_data_reg;
    assign TX_P_DATA = tx_data_reg;
    assign TX_D_VLD  = tx_vld_reg;

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl: frames are driven on the falling edge and
// outputs sampled on the falling edge; TX bytes are collected by a monitor.
module tb_sys_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  RdData = '0;
    logic        RdData_Valid = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic        FIFO_FULL = 1'b0;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic        CLK_EN;
    logic [3:0]  Address;
    logic        WrEn;
    logic        RdEn;
    logic [7:0]  WrData;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;

    int checks   = 0;
    int failures = 0;
    logic [7:0] tx_q[$];

    sys_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .ALU_OUT      (ALU_OUT),
        .ALU_OUT_VLD  (ALU_OUT_VLD),
        .FIFO_FULL    (FIFO_FULL),
        .ALU_EN       (ALU_EN),
        .ALU_FUN      (ALU_FUN),
        .CLK_EN       (CLK_EN),
        .Address      (Address),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .WrData       (WrData),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (TX_D_VLD) begin
            tx_q.push_back(TX_P_DATA);
            $display("txn tx byte=0x%02h", TX_P_DATA);
        end
        if (WrEn || RdEn || TX_D_VLD)
            chk("strobe_excl", 32'(int'(WrEn) + int'(RdEn) + int'(TX_D_VLD)), 32'd1);
    end

    // Returns on the falling edge of the cycle after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
        $display("txn rx byte=0x%02h", b);
    endtask

    task automatic wait_tx(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && tx_q.size() < n; i++) @(negedge CLK);
        chk(tag, 32'(tx_q.size()), 32'(n));
    endtask

    function automatic logic [31:0] all_outs();
        return {3'b0, ALU_EN, ALU_FUN, CLK_EN, Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD};
    endfunction

    initial begin
        repeat (3) @(negedge CLK);
        chk("reset_outs", all_outs(), 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        // Register write
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        chk("wr_en", 32'(WrEn), 32'd1);
        chk("wr_addr", 32'(Address), 32'h5);
        chk("wr_data", 32'(WrData), 32'h3C);
        @(negedge CLK);
        chk("wr_en_pulse", 32'(WrEn), 32'd0);
        repeat (3) @(negedge CLK);
        chk("wr_no_tx", 32'(tx_q.size()), 32'd0);

        // Register read, data valid two cycles after RdEn
        send_byte(8'hBB); send_byte(8'h05);
        chk("rd_en", 32'(RdEn), 32'd1);
        chk("rd_addr", 32'(Address), 32'h5);
        @(negedge CLK);
        chk("rd_en_pulse", 32'(RdEn), 32'd0);
        @(negedge CLK);
        RdData = 8'h3C; RdData_Valid = 1'b1;
        @(negedge CLK);
        RdData_Valid = 1'b0;
        wait_tx("rd_tx_cnt", 1, 10);
        if (tx_q.size() > 0) chk("rd_tx_byte", 32'(tx_q[0]), 32'h3C);
        repeat (4) @(negedge CLK);
        chk("rd_tx_once", 32'(tx_q.size()), 32'd1);
        tx_q.delete();

        // ALU with operands
        send_byte(8'hCC); send_byte(8'h0A);
        chk("opa_wr", {Address, WrEn, WrData}, {4'h0, 1'b1, 8'h0A});
        send_byte(8'h14);
        chk("opb_wr", {Address, WrEn, WrData}, {4'h1, 1'b1, 8'h14});
        send_byte(8'h02);
        chk("alu_en", {ALU_EN, CLK_EN, ALU_FUN}, {1'b1, 1'b1, 4'h2});
        @(negedge CLK);
        chk("alu_en_pulse", {ALU_EN, CLK_EN}, {1'b0, 1'b1});
        ALU_OUT = 16'h00C8; ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0;
        chk("clk_en_drop", 32'(CLK_EN), 32'd0);
        wait_tx("alu_tx_cnt", 2, 10);
        if (tx_q.size() >= 2) begin
            chk("alu_tx_lo", 32'(tx_q[0]), 32'hC8);
            chk("alu_tx_hi", 32'(tx_q[1]), 32'h00);
        end
        chk("alu_fun_hold", 32'(ALU_FUN), 32'h2);
        tx_q.delete();

        // ALU without operands under FIFO backpressure
        FIFO_FULL = 1'b1;
        send_byte(8'hDD); send_byte(8'h00);
        chk("nop_alu_en", {ALU_EN, ALU_FUN, WrEn}, {1'b1, 4'h0, 1'b0});
        @(negedge CLK);
        ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0;
        repeat (5) @(negedge CLK);
        chk("full_no_tx", 32'(tx_q.size()), 32'd0);
        FIFO_FULL = 1'b0;
        wait_tx("bp_tx_cnt", 2, 10);
        if (tx_q.size() >= 2) begin
            chk("bp_tx_lo", 32'(tx_q[0]), 32'h34);
            chk("bp_tx_hi", 32'(tx_q[1]), 32'h12);
        end
        repeat (4) @(negedge CLK);
        chk("bp_tx_total", 32'(tx_q.size()), 32'd2);
        tx_q.delete();

        // Read timeout: valid one cycle past the limit must be ignored
        send_byte(8'hBB); send_byte(8'h02);
        chk("to_rd_en", 32'(RdEn), 32'd1);
        repeat (15) @(negedge CLK);
        RdData = 8'h77; RdData_Valid = 1'b1;
        @(negedge CLK);
        RdData_Valid = 1'b0;
        repeat (5) @(negedge CLK);
        chk("to_no_tx", 32'(tx_q.size()), 32'd0);

        // Valid on the last allowed wait cycle is still accepted
        send_byte(8'hBB); send_byte(8'h03);
        repeat (14) @(negedge CLK);
        RdData = 8'h5A; RdData_Valid = 1'b1;
        @(negedge CLK);
        RdData_Valid = 1'b0;
        wait_tx("edge_tx_cnt", 1, 10);
        if (tx_q.size() > 0) chk("edge_tx_byte", 32'(tx_q[0]), 32'h5A);
        tx_q.delete();

        send_byte(8'hAA); send_byte(8'h07); send_byte(8'h99);
        chk("post_to_wr", {Address, WrEn, WrData}, {4'h7, 1'b1, 8'h99});

        // Illegal command in IDLE
        send_byte(8'h55);
        chk("illegal_ign", {ALU_EN, WrEn, RdEn, TX_D_VLD}, 4'b0000);
        send_byte(8'h33);
        chk("illegal_next", {ALU_EN, WrEn, RdEn}, 3'b000);

        // Reset mid-frame
        send_byte(8'hCC); send_byte(8'h01);
        chk("mid_opa_wr", {Address, WrEn, WrData}, {4'h0, 1'b1, 8'h01});
        RST = 1'b0;
        #1;
        chk("mid_rst_outs", all_outs(), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        send_byte(8'h02);
        chk("post_rst_ign", {ALU_EN, WrEn, RdEn, Address}, 7'd0);
        repeat (3) @(negedge CLK);
        chk("post_rst_no_tx", 32'(tx_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
